// File: rtl/noc_crossbar_switch.sv
// P x P flit crossbar for a virtual-channel router: routes each granted input flit to its
// destination output. It also supports static-straight-allocation (SSA) writes and an optional output register.
module noc_crossbar_switch #(
   parameter int unsigned V                         = 4,
   parameter int unsigned P                         = 5,
   parameter int unsigned Fpay                      = 32,
   parameter string       TOPOLOGY                  = "MESH",
   parameter string       MUX_TYPE                  = "ONE_HOT",
   parameter int unsigned ADD_PIPREG_AFTER_CROSSBAR = 0,
   parameter string       SSA_EN                    = "YES"
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [P*(P-1)-1:0]         granted_dest_port_all,
   input  logic [P*(2+V+Fpay)-1:0]    flit_in_all,
   input  logic [P-1:0]               ssa_flit_wr_all,
   output logic [P*(2+V+Fpay)-1:0]    flit_out_all,
   output logic [P-1:0]               flit_out_we_all
);
   localparam int unsigned FW     = 2 + V + Fpay;
   localparam int unsigned GW     = P - 1;
   localparam int unsigned KW     = (GW > 1) ? $clog2(GW) : 1;
   localparam int unsigned IW     = $clog2(P);
   localparam bit          SSA_ON = (SSA_EN == "YES");

   logic [FW-1:0]   flit_in [P];
   logic [P-1:0]    req     [P];
   logic [P-1:0]    src     [P];
   logic [KW-1:0]   gnt_k   [P];
   logic [KW-1:0]   sel     [P];
   logic [FW-1:0]   data_c  [P];
   logic [P-1:0]    any_gnt;
   logic [P-1:0]    we_c;
   logic [P*FW-1:0] data_all_c;

   // The topology name only labels the instance; it does not change the datapath.
   if (TOPOLOGY == "") begin : g_unnamed_topology
   end

   always_comb begin
      for (int i = 0; i < P; i++) flit_in[i] = flit_in_all[i*FW +: FW];
   end

   // Decode per-input grant fields into per-output source vectors (req[o][i]).
   // Index k of the select register numbers the other inputs of output o.
   always_comb begin
      any_gnt = '0;
      we_c    = '0;
      for (int o = 0; o < P; o++) begin
         req[o]   = '0;
         src[o]   = '0;
         gnt_k[o] = '0;
         for (int i = 0; i < P; i++) begin
            if (i != o) begin
               if (granted_dest_port_all[i*GW + ((o < i) ? o : o - 1)]) begin
                  req[o][i] = 1'b1;
                  gnt_k[o]  = gnt_k[o] | KW'((i < o) ? i : i - 1);
               end
            end
         end
         any_gnt[o] = |req[o];
         we_c[o]    = any_gnt[o] | (SSA_ON & ssa_flit_wr_all[o]);
         if (any_gnt[o]) begin
            src[o] = req[o];
         end else if (SSA_ON && ssa_flit_wr_all[o]) begin
            for (int i = 0; i < P; i++) begin
               if (i != o && sel[o] == KW'((i < o) ? i : i - 1)) src[o][i] = 1'b1;
            end
         end
      end
   end

   // Remember the last granting input per output for later SSA writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int o = 0; o < P; o++) sel[o] <= '0;
      end else begin
         for (int o = 0; o < P; o++) begin
            if (any_gnt[o]) sel[o] <= gnt_k[o];
         end
      end
   end

   if (MUX_TYPE == "BINARY") begin : g_binary
      logic [IW-1:0] src_idx [P];
      always_comb begin
         for (int o = 0; o < P; o++) begin
            src_idx[o] = '0;
            for (int i = 0; i < P; i++) begin
               if (src[o][i]) src_idx[o] = src_idx[o] | IW'(i);
            end
            data_c[o] = (|src[o]) ? flit_in[src_idx[o]] : '0;
         end
      end
   end else begin : g_one_hot
      always_comb begin
         for (int o = 0; o < P; o++) begin
            data_c[o] = '0;
            for (int i = 0; i < P; i++) data_c[o] = data_c[o] | ({FW{src[o][i]}} & flit_in[i]);
         end
      end
   end

   always_comb begin
      data_all_c = '0;
      for (int o = 0; o < P; o++) data_all_c[o*FW +: FW] = data_c[o];
   end

   if (ADD_PIPREG_AFTER_CROSSBAR != 0) begin : g_pipe
      always_ff @(posedge clk) begin
         if (reset) begin
            flit_out_all    <= '0;
            flit_out_we_all <= '0;
         end else begin
            flit_out_all    <= data_all_c;
            flit_out_we_all <= we_c;
         end
      end
   end else begin : g_comb
      assign flit_out_all    = reset ? '0 : data_all_c;
      assign flit_out_we_all = reset ? '0 : we_c;
   end

endmodule

// File: tb/tb_noc_crossbar_switch.sv
// Bench for noc_crossbar_switch: four configurations share one stimulus stream and are
// compared against a destination-table reference model.
module tb_noc_crossbar_switch;
   localparam int P  = 5;
   localparam int V  = 4;
   localparam int FP = 32;
   localparam int FW = 2 + V + FP;
   localparam int GW = P - 1;

   logic clk = 1'b0;
   logic reset;
   logic [P*GW-1:0] gnt;
   logic [P*FW-1:0] flit_in;
   logic [P-1:0]    ssa_w;
   logic [P*FW-1:0] out_def, out_bin, out_nossa, out_pipe;
   logic [P-1:0]    we_def, we_bin, we_nossa, we_pipe;

   int            dest  [P];
   logic [FW-1:0] fl    [P];
   int            sel_m [P];
   logic [P-1:0]  ssa;
   logic [P*FW-1:0] raw_out, ey_out, en_out, pp_out, ev;
   logic [P-1:0]    raw_we, ey_we, en_we, pp_we;
   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   noc_crossbar_switch u_def (.clk(clk), .reset(reset), .granted_dest_port_all(gnt),
      .flit_in_all(flit_in), .ssa_flit_wr_all(ssa_w), .flit_out_all(out_def), .flit_out_we_all(we_def));
   noc_crossbar_switch #(.MUX_TYPE("BINARY")) u_bin (.clk(clk), .reset(reset), .granted_dest_port_all(gnt),
      .flit_in_all(flit_in), .ssa_flit_wr_all(ssa_w), .flit_out_all(out_bin), .flit_out_we_all(we_bin));
   noc_crossbar_switch #(.SSA_EN("NO")) u_nossa (.clk(clk), .reset(reset), .granted_dest_port_all(gnt),
      .flit_in_all(flit_in), .ssa_flit_wr_all(ssa_w), .flit_out_all(out_nossa), .flit_out_we_all(we_nossa));
   noc_crossbar_switch #(.ADD_PIPREG_AFTER_CROSSBAR(1)) u_pipe (.clk(clk), .reset(reset), .granted_dest_port_all(gnt),
      .flit_in_all(flit_in), .ssa_flit_wr_all(ssa_w), .flit_out_all(out_pipe), .flit_out_we_all(we_pipe));

   // Idle cycle: no grants, no SSA, fresh random flits.
   task automatic clear();
      for (int i = 0; i < P; i++) begin
         dest[i] = -1;
         fl[i]   = FW'({$urandom(), $urandom()});
      end
      ssa = '0;
   endtask

   // Drive the destination table as grant fields, build expectations, move to the sample point.
   task automatic apply();
      int src;
      gnt   = '0;
      ssa_w = ssa;
      for (int i = 0; i < P; i++) begin
         flit_in[i*FW +: FW] = fl[i];
         if (dest[i] >= 0) gnt[i*GW + ((dest[i] < i) ? dest[i] : dest[i] - 1)] = 1'b1;
      end
      raw_out = '0; raw_we = '0; en_out = '0; en_we = '0;
      for (int o = 0; o < P; o++) begin
         src = -1;
         for (int i = 0; i < P; i++) if (dest[i] == o) src = i;
         if (src >= 0) begin
            raw_we[o] = 1'b1; raw_out[o*FW +: FW] = fl[src];
            en_we[o]  = 1'b1; en_out[o*FW +: FW]  = fl[src];
         end else if (ssa[o]) begin
            raw_we[o] = 1'b1; raw_out[o*FW +: FW] = fl[sel_m[o]];
         end
      end
      ey_out = reset ? '0 : raw_out;
      ey_we  = reset ? '0 : raw_we;
      if (reset) begin
         en_out = '0;
         en_we  = '0;
      end
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int o = 0; o < P; o++) sel_m[o] = (o == 0) ? 1 : 0;
         pp_out = '0; pp_we = '0;
      end else begin
         for (int o = 0; o < P; o++)
            for (int i = 0; i < P; i++) if (dest[i] == o) sel_m[o] = i;
         pp_out = raw_out; pp_we = raw_we;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; clear(); dest[2] = 1; apply();
      nvec++; if (we_def !== 5'b0 || out_def !== '0) begin nerr++; $display("FAIL reset_comb got we=%b out=%h exp 0", we_def, out_def); end
      nvec++; if (we_pipe !== 5'b0 || out_pipe !== '0) begin nerr++; $display("FAIL reset_pipe got we=%b out=%h exp 0", we_pipe, out_pipe); end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_single_grant();
      clear(); dest[0] = 1; fl[0] = 38'h2_DEAD_BEEF; apply();
      ev = '0; ev[1*FW +: FW] = 38'h2_DEAD_BEEF;
      nvec++; if (we_def !== 5'b00010) begin nerr++; $display("FAIL single_we got %b exp 00010", we_def); end
      nvec++; if (out_def !== ev) begin nerr++; $display("FAIL single_data got %h exp %h", out_def, ev); end
      nvec++; if (we_bin !== 5'b00010 || out_bin !== ev) begin nerr++; $display("FAIL single_bin got we=%b out=%h exp we=00010 out=%h", we_bin, out_bin, ev); end
      tick();
   endtask

   task automatic test_dual_grant();
      clear(); dest[3] = 4; dest[4] = 0; apply();
      ev = '0; ev[4*FW +: FW] = fl[3]; ev[0 +: FW] = fl[4];
      nvec++; if (we_def !== 5'b10001 || out_def !== ev) begin nerr++; $display("FAIL dual_def got we=%b out=%h exp we=10001 out=%h", we_def, out_def, ev); end
      nvec++; if (we_bin !== 5'b10001 || out_bin !== ev) begin nerr++; $display("FAIL dual_bin got we=%b out=%h exp we=10001 out=%h", we_bin, out_bin, ev); end
      tick();
   endtask

   task automatic test_ssa();
      clear(); dest[2] = 3; apply(); tick();
      clear(); ssa = 5'b01000; fl[2] = 38'h1; apply();
      ev = '0; ev[3*FW +: FW] = 38'h1;
      nvec++; if (we_def !== 5'b01000 || out_def !== ev) begin nerr++; $display("FAIL ssa_def got we=%b out=%h exp we=01000 out=%h", we_def, out_def, ev); end
      nvec++; if (we_bin !== 5'b01000 || out_bin !== ev) begin nerr++; $display("FAIL ssa_bin got we=%b out=%h exp we=01000 out=%h", we_bin, out_bin, ev); end
      nvec++; if (we_nossa !== 5'b0 || out_nossa !== '0) begin nerr++; $display("FAIL ssa_disabled got we=%b out=%h exp 0", we_nossa, out_nossa); end
      tick();
      clear(); dest[1] = 3; ssa = 5'b01000; apply();
      ev = '0; ev[3*FW +: FW] = fl[1];
      nvec++; if (we_def !== 5'b01000 || out_def !== ev) begin nerr++; $display("FAIL ssa_with_grant got we=%b out=%h exp we=01000 out=%h", we_def, out_def, ev); end
      tick();
   endtask

   task automatic test_pipeline();
      logic [FW-1:0] f;
      clear(); apply(); tick();
      clear(); dest[1] = 0; f = fl[1]; apply();
      nvec++; if (we_pipe !== 5'b0) begin nerr++; $display("FAIL pipe_early got we=%b exp 00000", we_pipe); end
      nvec++; if (we_def !== 5'b00001) begin nerr++; $display("FAIL pipe_comb_ref got we=%b exp 00001", we_def); end
      tick();
      clear(); apply();
      ev = '0; ev[0 +: FW] = f;
      nvec++; if (we_pipe !== 5'b00001 || out_pipe !== ev) begin nerr++; $display("FAIL pipe_late got we=%b out=%h exp we=00001 out=%h", we_pipe, out_pipe, ev); end
      tick();
      clear(); apply();
      nvec++; if (we_pipe !== 5'b0 || out_pipe !== '0) begin nerr++; $display("FAIL pipe_once got we=%b out=%h exp 0", we_pipe, out_pipe); end
      tick();
   endtask

   task automatic test_reset_midop();
      clear(); dest[2] = 1; apply(); tick();
      reset = 1'b1; clear(); dest[2] = 1; apply();
      nvec++; if (we_def !== 5'b0 || out_def !== '0) begin nerr++; $display("FAIL midreset_comb got we=%b out=%h exp 0", we_def, out_def); end
      tick();
      reset = 1'b0; clear(); ssa = 5'b00010; apply();
      nvec++; if (we_pipe !== 5'b0 || out_pipe !== '0) begin nerr++; $display("FAIL midreset_pipe got we=%b out=%h exp 0", we_pipe, out_pipe); end
      ev = '0; ev[1*FW +: FW] = fl[0];
      nvec++; if (we_def !== 5'b00010 || out_def !== ev) begin nerr++; $display("FAIL midreset_sel got we=%b out=%h exp we=00010 out=%h", we_def, out_def, ev); end
      tick();
   endtask

   task automatic test_sweep();
      for (int i = 0; i < P; i++) begin
         for (int o = 0; o < P; o++) begin
            if (o != i) begin
               clear(); dest[i] = o; apply();
               ev = '0; ev[o*FW +: FW] = fl[i];
               nvec++;
               if (we_def !== 5'(1 << o) || out_def !== ev || we_bin !== 5'(1 << o) || out_bin !== ev) begin
                  nerr++;
                  $display("FAIL sweep in=%0d out=%0d got we=%b/%b exp we=%b", i, o, we_def, we_bin, 5'(1 << o));
               end
               tick();
            end
         end
      end
   endtask

   task automatic test_random();
      logic [P-1:0] taken;
      int o;
      for (int c = 0; c < 300; c++) begin
         clear();
         taken = '0;
         for (int i = 0; i < P; i++) begin
            if ($urandom_range(0, 3) != 0) begin
               o = $urandom_range(0, P - 2);
               if (o >= i) o++;
               if (!taken[o]) begin dest[i] = o; taken[o] = 1'b1; end
            end
         end
         ssa   = P'($urandom());
         reset = ($urandom_range(0, 29) == 0);
         apply();
         nvec++; if (we_def !== ey_we || out_def !== ey_out) begin nerr++; $display("FAIL rand_def c=%0d got we=%b out=%h exp we=%b out=%h", c, we_def, out_def, ey_we, ey_out); end
         nvec++; if (we_bin !== ey_we || out_bin !== ey_out) begin nerr++; $display("FAIL rand_bin c=%0d got we=%b out=%h exp we=%b out=%h", c, we_bin, out_bin, ey_we, ey_out); end
         nvec++; if (we_nossa !== en_we || out_nossa !== en_out) begin nerr++; $display("FAIL rand_nossa c=%0d got we=%b out=%h exp we=%b out=%h", c, we_nossa, out_nossa, en_we, en_out); end
         nvec++; if (we_pipe !== pp_we || out_pipe !== pp_out) begin nerr++; $display("FAIL rand_pipe c=%0d got we=%b out=%h exp we=%b out=%h", c, we_pipe, out_pipe, pp_we, pp_out); end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clear();
      raw_out = '0; raw_we = '0;
      apply();
      tick();
      test_reset();
      test_single_grant();
      test_dual_grant();
      test_ssa();
      test_pipeline();
      test_reset_midop();
      test_sweep();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
